// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: burst read/write sequencer for a single-port SRAM with one-cycle read latency
module sram_burst_ctrl #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [DW-1:0] wdata,
    output logic          rdata_valid,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, RDRAIN} state_t;
    state_t        state, state_n;
    logic [AW-1:0] cur_addr, cur_addr_n, cnt, cnt_n, mem_addr_n;
    logic [DW-1:0] mem_data_n;
    logic          mem_wr_en_n, rdata_valid_n, wdata_ready_n;
    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign rdata     = mem_rdata;
    // next-state and registered-output values; cnt holds beats remaining minus one
    always_comb begin
        state_n       = state;
        cur_addr_n    = cur_addr;
        cnt_n         = cnt;
        mem_addr_n    = mem_addr;
        mem_data_n    = mem_data;
        mem_wr_en_n   = 1'b0;
        rdata_valid_n = state == READ;
        wdata_ready_n = wdata_ready;
        case (state)
            IDLE: if (req_valid) begin
                cnt_n         = req_len;
                wdata_ready_n = req_write;
                state_n       = req_write ? WRITE : READ;
                cur_addr_n    = req_write ? req_addr : req_addr + 1'b1;
                mem_addr_n    = req_write ? mem_addr : req_addr;
            end
            WRITE: if (wdata_valid) begin
                mem_wr_en_n = 1'b1;
                mem_addr_n  = cur_addr;
                mem_data_n  = wdata;
                cur_addr_n  = cur_addr + 1'b1;
                cnt_n       = cnt - 1'b1;
                if (cnt == '0) begin
                    state_n       = IDLE;
                    wdata_ready_n = 1'b0;
                end
            end
            READ: if (cnt == '0) begin
                state_n = RDRAIN;
            end else begin
                mem_addr_n = cur_addr;
                cur_addr_n = cur_addr + 1'b1;
                cnt_n      = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    // state and output registers, cleared asynchronously so a burst in flight is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cur_addr    <= '0;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_wr_en   <= 1'b0;
            rdata_valid <= 1'b0;
            wdata_ready <= 1'b0;
        end else begin
            state       <= state_n;
            cur_addr    <= cur_addr_n;
            cnt         <= cnt_n;
            mem_addr    <= mem_addr_n;
            mem_data    <= mem_data_n;
            mem_wr_en   <= mem_wr_en_n;
            rdata_valid <= rdata_valid_n;
            wdata_ready <= wdata_ready_n;
        end
    end
endmodule
